// File: rtl/MD_pkg.sv
// Shared cell-geometry constants for the MD cell-list datapath.
package MD_pkg;

  localparam int unsigned NUM_CELL_FOLDS       = 2;
  localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
  localparam int unsigned CELL_ID_WIDTH        = 1;
  localparam int unsigned CELL_FOLD_ID_WIDTH   = 1;
  localparam int unsigned X_DIM                = 2;
  localparam int unsigned Y_DIM                = 2;
  localparam int unsigned Z_DIM                = 2;

endpackage

// File: rtl/gcid_to_cid_filter_pkg.sv
// Types shared by the global-to-local cell id filter and its per-axis decoder.
package gcid_to_cid_filter_pkg;

  import MD_pkg::*;

  typedef logic [GLOBAL_CELL_ID_WIDTH-1:0] gcell_t;
  typedef logic [CELL_ID_WIDTH-1:0]        cid_t;
  typedef logic [CELL_FOLD_ID_WIDTH-1:0]   fold_t;

  typedef struct packed {
    logic  match;
    cid_t  cid;
    fold_t fold_id;
  } axis_res_t;

endpackage

// File: rtl/gcid_to_cid_1d.sv
// Single-axis decode: finds the lowest fold whose window contains the global cell.
module gcid_to_cid_1d
  import MD_pkg::*, gcid_to_cid_filter_pkg::*;
#(
  parameter int unsigned GCELL_ID [NUM_CELL_FOLDS] = '{default: 0},
  parameter int unsigned DIM                       = 1
) (
  input  gcell_t i_gcid,
  output cid_t   o_cid,
  output fold_t  o_fold_id,
  output logic   o_match
);

  gcell_t off;

  // Walk folds high to low so the lowest matching fold is the last writer.
  always_comb begin
    off       = '0;
    o_match   = 1'b0;
    o_cid     = '0;
    o_fold_id = '0;
    for (int f = int'(NUM_CELL_FOLDS) - 1; f >= 0; f--) begin
      off = i_gcid - gcell_t'(GCELL_ID[f]);
      if (32'(off) < DIM) begin
        o_match   = 1'b1;
        o_cid     = cid_t'(off);
        o_fold_id = fold_t'(f);
      end
    end
  end

endmodule

// File: rtl/gcid_to_cid_filter.sv
// Two-stage pipeline mapping a global cell id to a local cell/fold id, with
// optional miss dropping and saturating hit/miss counters.
module gcid_to_cid_filter
  import MD_pkg::*, gcid_to_cid_filter_pkg::*;
#(
  parameter int unsigned GCELL_X [NUM_CELL_FOLDS] = '{default: 0},
  parameter int unsigned GCELL_Y [NUM_CELL_FOLDS] = '{default: 0},
  parameter int unsigned GCELL_Z [NUM_CELL_FOLDS] = '{default: 0},
  parameter int unsigned DATA_WIDTH               = 96,
  parameter bit          DROP_MISS                = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_gcid,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [3*CELL_ID_WIDTH-1:0]        o_cid,
  output logic [3*CELL_FOLD_ID_WIDTH-1:0]   o_fold_id,
  output logic                              o_hit,
  output logic [DATA_WIDTH-1:0]             o_data,
  input  logic                              i_cnt_clr,
  output logic [31:0]                       o_hit_cnt,
  output logic [31:0]                       o_miss_cnt
);

  localparam int unsigned GW = GLOBAL_CELL_ID_WIDTH;

  logic [2:0]      dec_match;
  cid_t  [2:0]     dec_cid;
  fold_t [2:0]     dec_fold;
  axis_res_t [2:0] dec_res;

  gcid_to_cid_1d #(.GCELL_ID(GCELL_X), .DIM(X_DIM)) u_dec_x (
    .i_gcid    (i_gcid[GW-1:0]),
    .o_cid     (dec_cid[0]),
    .o_fold_id (dec_fold[0]),
    .o_match   (dec_match[0])
  );

  gcid_to_cid_1d #(.GCELL_ID(GCELL_Y), .DIM(Y_DIM)) u_dec_y (
    .i_gcid    (i_gcid[2*GW-1:GW]),
    .o_cid     (dec_cid[1]),
    .o_fold_id (dec_fold[1]),
    .o_match   (dec_match[1])
  );

  gcid_to_cid_1d #(.GCELL_ID(GCELL_Z), .DIM(Z_DIM)) u_dec_z (
    .i_gcid    (i_gcid[3*GW-1:2*GW]),
    .o_cid     (dec_cid[2]),
    .o_fold_id (dec_fold[2]),
    .o_match   (dec_match[2])
  );

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      dec_res[a] = '{match: dec_match[a], cid: dec_cid[a], fold_id: dec_fold[a]};
    end
  end

  // Stage registers
  logic                            s1_valid_q;
  axis_res_t [2:0]                 s1_res_q;
  logic [DATA_WIDTH-1:0]           s1_data_q;
  logic                            s2_valid_q;
  logic                            s2_hit_q;
  logic [3*CELL_ID_WIDTH-1:0]      s2_cid_q;
  logic [3*CELL_FOLD_ID_WIDTH-1:0] s2_fold_q;
  logic [DATA_WIDTH-1:0]           s2_data_q;
  logic [31:0]                     hit_cnt_q, hit_cnt_d;
  logic [31:0]                     miss_cnt_q, miss_cnt_d;

  logic                            s1_hit;
  logic                            s1_drop;
  logic                            s1_adv;
  logic                            s2_ready;
  logic                            s2_load;
  logic                            in_fire;
  logic [3*CELL_ID_WIDTH-1:0]      s1_cid;
  logic [3*CELL_FOLD_ID_WIDTH-1:0] s1_fold;

  always_comb begin
    s1_hit   = s1_res_q[0].match & s1_res_q[1].match & s1_res_q[2].match;
    s1_cid   = '0;
    s1_fold  = '0;
    if (s1_hit) begin
      s1_cid  = {s1_res_q[2].cid, s1_res_q[1].cid, s1_res_q[0].cid};
      s1_fold = {s1_res_q[2].fold_id, s1_res_q[1].fold_id, s1_res_q[0].fold_id};
    end
    s2_ready = !s2_valid_q || o_ready;
    // A dropped miss retires from S1 regardless of downstream backpressure.
    s1_drop  = DROP_MISS && !s1_hit;
    s1_adv   = s1_valid_q && (s2_ready || s1_drop);
    s2_load  = s1_adv && !s1_drop;
    i_ready  = !s1_valid_q || s1_adv;
    in_fire  = i_valid && i_ready;
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (i_cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (s1_adv) begin
      if (s1_hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!s1_hit && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_cid_q   <= '0;
      s2_fold_q  <= '0;
      s2_data_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_res_q   <= dec_res;
        s1_data_q  <= i_data;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_hit_q   <= s1_hit;
        s2_cid_q   <= s1_cid;
        s2_fold_q  <= s1_fold;
        s2_data_q  <= s1_data_q;
      end else if (o_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_hit      = s2_hit_q;
  assign o_cid      = s2_cid_q;
  assign o_fold_id  = s2_fold_q;
  assign o_data     = s2_data_q;
  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_gcid_to_cid_filter.sv
// Randomized + directed bench for gcid_to_cid_filter: one dropping and one forwarding instance.
module tb_gcid_to_cid_filter;
  import MD_pkg::*;

  localparam int unsigned GW  = GLOBAL_CELL_ID_WIDTH;
  localparam int unsigned DW  = 96;
  localparam int          MOD = 2 ** GW;
  localparam int          CW1 = 2 ** CELL_ID_WIDTH;
  localparam int          FW1 = 2 ** CELL_FOLD_ID_WIDTH;
  localparam int unsigned GA   [NUM_CELL_FOLDS] = '{0, 4};
  localparam int unsigned GX_B [NUM_CELL_FOLDS] = '{7, 4};

  typedef logic [3*CELL_ID_WIDTH-1:0]      cid3_t;
  typedef logic [3*CELL_FOLD_ID_WIDTH-1:0] fold3_t;
  typedef struct packed {
    logic          hit;
    cid3_t         cid;
    fold3_t        fold;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk, rst_n, i_valid, i_cnt_clr, o_ready;
  logic [3*GW-1:0]   i_gcid;
  logic [DW-1:0]     i_data;
  logic              a_i_ready, a_o_valid, a_o_hit, b_i_ready, b_o_valid, b_o_hit;
  cid3_t             a_o_cid, b_o_cid;
  fold3_t            a_o_fold, b_o_fold;
  logic [DW-1:0]     a_o_data, b_o_data;
  logic [31:0]       a_hit_cnt, a_miss_cnt, b_hit_cnt, b_miss_cnt;

  gcid_to_cid_filter #(
    .GCELL_X(GA), .GCELL_Y(GA), .GCELL_Z(GA), .DATA_WIDTH(DW), .DROP_MISS(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(a_i_ready), .i_gcid(i_gcid),
    .i_data(i_data), .o_valid(a_o_valid), .o_ready(o_ready), .o_cid(a_o_cid),
    .o_fold_id(a_o_fold), .o_hit(a_o_hit), .o_data(a_o_data), .i_cnt_clr(i_cnt_clr),
    .o_hit_cnt(a_hit_cnt), .o_miss_cnt(a_miss_cnt)
  );

  gcid_to_cid_filter #(
    .GCELL_X(GX_B), .GCELL_Y(GA), .GCELL_Z(GA), .DATA_WIDTH(DW), .DROP_MISS(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(b_i_ready), .i_gcid(i_gcid),
    .i_data(i_data), .o_valid(b_o_valid), .o_ready(o_ready), .o_cid(b_o_cid),
    .o_fold_id(b_o_fold), .o_hit(b_o_hit), .o_data(b_o_data), .i_cnt_clr(i_cnt_clr),
    .o_hit_cnt(b_hit_cnt), .o_miss_cnt(b_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  exp_t   q_a[$], q_b[$];
  longint hit_m_a, miss_m_a, hit_m_b, miss_m_b;
  int     n_out_a, n_out_b;
  bit     stall_a, stall_b;
  exp_t   held_a, held_b, mon_e;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: offset of g from each fold base, modulo the global id range.
  function automatic void axis_ref(input int g, input int b0, input int b1, input int dim,
                                   output bit m, output int cid, output int fold);
    int base [2];
    int off;
    base[0] = b0;
    base[1] = b1;
    m = 1'b0; cid = 0; fold = 0;
    for (int f = 0; f < 2; f++) begin
      off = ((g - base[f]) % MOD + MOD) % MOD;
      if (!m && off < dim) begin
        m = 1'b1; cid = off; fold = f;
      end
    end
  endfunction

  function automatic exp_t model(input logic [3*GW-1:0] g, input logic [DW-1:0] d,
                                 input bit is_b);
    bit   m [3];
    int   c [3];
    int   f [3];
    exp_t e;
    axis_ref(int'(g[GW-1:0]), is_b ? 7 : 0, 4, int'(X_DIM), m[0], c[0], f[0]);
    axis_ref(int'(g[2*GW-1:GW]), 0, 4, int'(Y_DIM), m[1], c[1], f[1]);
    axis_ref(int'(g[3*GW-1:2*GW]), 0, 4, int'(Z_DIM), m[2], c[2], f[2]);
    e.hit  = m[0] & m[1] & m[2];
    e.data = d;
    e.cid  = '0;
    e.fold = '0;
    if (e.hit) begin
      e.cid  = cid3_t'(c[2] * CW1 * CW1 + c[1] * CW1 + c[0]);
      e.fold = fold3_t'(f[2] * FW1 * FW1 + f[1] * FW1 + f[0]);
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [3*GW-1:0] rand_hit_a();
    logic [3*GW-1:0] g;
    for (int n = 0; n < 1000; n++) begin
      g = (3*GW)'($urandom);
      if (model(g, '0, 1'b0).hit) return g;
    end
    return {3'd5, 3'd1, 3'd4};
  endfunction

  // Scoreboard: acceptance and output handshakes sampled at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (i_cnt_clr) begin
        hit_m_a = 0; miss_m_a = 0; hit_m_b = 0; miss_m_b = 0;
      end
      if (i_valid && a_i_ready) begin
        mon_e = model(i_gcid, i_data, 1'b0);
        if (mon_e.hit) begin
          q_a.push_back(mon_e);
          if (hit_m_a < 64'hFFFF_FFFF) hit_m_a++;
        end else if (miss_m_a < 64'hFFFF_FFFF) miss_m_a++;
      end
      if (i_valid && b_i_ready) begin
        mon_e = model(i_gcid, i_data, 1'b1);
        q_b.push_back(mon_e);
        if (mon_e.hit) begin
          if (hit_m_b < 64'hFFFF_FFFF) hit_m_b++;
        end else if (miss_m_b < 64'hFFFF_FFFF) miss_m_b++;
      end
      if (stall_a)
        check_eq("a_stall_hold", 128'({a_o_valid, a_o_hit, a_o_cid, a_o_fold, a_o_data}),
                 128'({1'b1, held_a}));
      if (stall_b)
        check_eq("b_stall_hold", 128'({b_o_valid, b_o_hit, b_o_cid, b_o_fold, b_o_data}),
                 128'({1'b1, held_b}));
      stall_a = a_o_valid && !o_ready;
      stall_b = b_o_valid && !o_ready;
      held_a  = {a_o_hit, a_o_cid, a_o_fold, a_o_data};
      held_b  = {b_o_hit, b_o_cid, b_o_fold, b_o_data};
      if (a_o_valid && o_ready) begin
        n_out_a++;
        if (q_a.size() == 0) check_eq("a_extra_out", 128'(a_o_valid), 128'(0));
        else check_eq("a_out", 128'({a_o_hit, a_o_cid, a_o_fold, a_o_data}),
                      128'(q_a.pop_front()));
      end
      if (b_o_valid && o_ready) begin
        n_out_b++;
        if (q_b.size() == 0) check_eq("b_extra_out", 128'(b_o_valid), 128'(0));
        else check_eq("b_out", 128'({b_o_hit, b_o_cid, b_o_fold, b_o_data}),
                      128'(q_b.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3*GW-1:0] g, input logic [DW-1:0] d);
    i_valid = 1'b1;
    i_gcid  = g;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 50 && (q_a.size() != 0 || q_b.size() != 0); k++) tick();
    repeat (3) tick();
    check_eq("drain_empty", 128'(q_a.size() + q_b.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3*GW-1:0] hl [10];
  logic [DW-1:0]   hd [10];
  logic [DW-1:0]   d0;
  bit              saw;
  int              k, n0;

  initial begin
    rst_n = 1'b1; i_valid = 1'b0; i_gcid = '0; i_data = '0; i_cnt_clr = 1'b0; o_ready = 1'b1;
    hit_m_a = 0; miss_m_a = 0; hit_m_b = 0; miss_m_b = 0; n_out_a = 0; n_out_b = 0;
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_a_valid", 128'(a_o_valid), 128'(0));
    check_eq("rst_a_outs", 128'({a_o_hit, a_o_cid, a_o_fold, a_o_data}), 128'(0));
    check_eq("rst_a_cnts", 128'({a_hit_cnt, a_miss_cnt}), 128'(0));
    check_eq("rst_b_outs", 128'({b_o_valid, b_o_hit, b_o_cid, b_o_fold, b_o_data}), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_iready", 128'({a_i_ready, b_i_ready}), 128'(2'b11));
    tick();

    // Basic hit, two-cycle latency
    d0 = rand_data();
    pulse({3'd5, 3'd1, 3'd4}, d0);
    check_eq("lat_c1_valid", 128'(a_o_valid), 128'(0));
    tick();
    check_eq("lat_c2_valid", 128'(a_o_valid), 128'(1));
    check_eq("hit_fields", 128'({a_o_hit, a_o_cid, a_o_fold}), 128'({1'b1, 3'b110, 3'b101}));
    check_eq("hit_data", 128'(a_o_data), 128'(d0));
    tick();
    check_eq("hit_cnt_1", 128'({a_hit_cnt, a_miss_cnt}), 128'({32'd1, 32'd0}));

    // Miss on x: dropped by A, forwarded by B
    saw = 1'b0;
    pulse({3'd5, 3'd1, 3'd3}, rand_data());
    saw |= a_o_valid;
    tick();
    saw |= a_o_valid;
    check_eq("miss_b_out", 128'({b_o_valid, b_o_hit, b_o_cid, b_o_fold}), 128'({1'b1, 7'd0}));
    tick();
    saw |= a_o_valid;
    tick();
    saw |= a_o_valid;
    check_eq("miss_a_dropped", 128'(saw), 128'(0));
    check_eq("miss_cnt_a", 128'({a_hit_cnt, a_miss_cnt}), 128'({32'd1, 32'd1}));
    check_eq("miss_cnt_b", 128'(b_miss_cnt), 128'(1));

    // Wrapped window on B's x axis
    pulse({3'd0, 3'd0, 3'd0}, rand_data());
    tick();
    check_eq("wrap_b", 128'({b_o_valid, b_o_hit, b_o_cid, b_o_fold}),
             128'({1'b1, 1'b1, 3'b001, 3'b000}));
    drain();

    // Clear coincident with an S1 retirement
    pulse({3'd5, 3'd1, 3'd4}, rand_data());
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    check_eq("clr_coincident", 128'({a_hit_cnt, a_miss_cnt, b_hit_cnt}), 128'(0));
    drain();
    check_eq("clr_stays_zero", 128'({a_hit_cnt, a_miss_cnt}), 128'(0));

    // Saturation from a preset count
    force dut_a.hit_cnt_q = 32'hFFFF_FFFD;
    hit_m_a = 64'hFFFF_FFFD;
    @(negedge clk);
    release dut_a.hit_cnt_q;
    tick();
    check_eq("sat_preset", 128'(a_hit_cnt), 128'(32'hFFFF_FFFD));
    for (int n = 0; n < 4; n++) begin
      i_valid = 1'b1; i_gcid = rand_hit_a(); i_data = rand_data();
      tick();
    end
    drain();
    check_eq("sat_max", 128'(a_hit_cnt), 128'(32'hFFFF_FFFF));
    check_eq("sat_model", 128'(a_hit_cnt), 128'(hit_m_a));
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;

    // Ten back-to-back hits with a downstream stall
    for (int n = 0; n < 10; n++) begin
      hl[n] = rand_hit_a();
      hd[n] = rand_data();
    end
    saw = 1'b0;
    k = 0;
    n0 = n_out_a;
    for (int cyc = 0; cyc < 100 && k < 10; cyc++) begin
      o_ready = !(cyc >= 3 && cyc <= 6);
      i_valid = 1'b1; i_gcid = hl[k]; i_data = hd[k];
      @(negedge clk);
      if (!o_ready && a_o_valid && !a_i_ready) saw = 1'b1;
      if (a_i_ready) k++;
      tick();
    end
    check_eq("bp_all_sent", 128'(k), 128'(10));
    drain();
    check_eq("bp_iready_low", 128'(saw), 128'(1));
    check_eq("bp_out_count", 128'(n_out_a - n0), 128'(10));

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_gcid  = (3*GW)'($urandom);
      i_data  = rand_data();
      o_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check_eq("rand_a_hit_cnt", 128'(a_hit_cnt), 128'(hit_m_a));
    check_eq("rand_a_miss_cnt", 128'(a_miss_cnt), 128'(miss_m_a));
    check_eq("rand_b_hit_cnt", 128'(b_hit_cnt), 128'(hit_m_b));
    check_eq("rand_b_miss_cnt", 128'(b_miss_cnt), 128'(miss_m_b));

    // Reset with two items in flight
    o_ready = 1'b0;
    pulse({3'd5, 3'd1, 3'd4}, rand_data());
    pulse({3'd5, 3'd1, 3'd5}, rand_data());
    check_eq("inflight_valid", 128'(a_o_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 128'({a_o_valid, b_o_valid}), 128'(0));
    q_a.delete();
    q_b.delete();
    hit_m_a = 0; miss_m_a = 0; hit_m_b = 0; miss_m_b = 0;
    n0 = n_out_a + n_out_b;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = 1'b1;
    repeat (6) tick();
    check_eq("rst_no_emit", 128'(n_out_a + n_out_b - n0), 128'(0));
    check_eq("rst_after_state", 128'({a_i_ready, a_hit_cnt, a_miss_cnt}), 128'({1'b1, 64'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcid_to_cid_filter.md
GCID_TO_CID_FILTER -- requirements
Module: gcid_to_cid_filter

Interface
REQ-001 SHALL have parameter GCELL_X[NUM_CELL_FOLDS], default '{0}, meaning the global X base cell of each local fold.
REQ-002 SHALL have parameter GCELL_Y[NUM_CELL_FOLDS], default '{0}, meaning the global Y base cell of each fold.
REQ-003 SHALL have parameter GCELL_Z[NUM_CELL_FOLDS], default '{0}, meaning the global Z base cell of each fold.
REQ-004 SHALL have parameter DATA_WIDTH, default 96, meaning the opaque payload width carried alongside the gcid.
REQ-005 SHALL have parameter DROP_MISS, default 1, meaning misses are dropped (1) or forwarded with o_hit=0 (0).
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk input 1 bit clock; rst_n input 1 bit asynchronous active-low reset.
REQ-007 SHALL have ports i_valid in 1, i_ready out 1, i_gcid in 3*GLOBAL_CELL_ID_WIDTH {z,y,x}, i_data in DATA_WIDTH.
REQ-008 SHALL have ports o_valid out 1, o_ready in 1, o_cid out 3*CELL_ID_WIDTH {z,y,x}, o_fold_id out 3*CELL_FOLD_ID_WIDTH {z,y,x}, o_hit out 1, o_data out DATA_WIDTH.
REQ-009 SHALL have ports i_cnt_clr in 1 and o_hit_cnt / o_miss_cnt out 32 bits each.

Function
REQ-010 Per axis, fold f SHALL match when (g - GCELL[f]) mod 2^GLOBAL_CELL_ID_WIDTH < DIM (X_DIM/Y_DIM/Z_DIM).
REQ-011 On multiple matching folds, the lowest f SHALL win; axis cid = (g - GCELL[f]) truncated to CELL_ID_WIDTH; axis fold id = f.
REQ-012 hit SHALL be the AND of all three axis matches; on miss, o_cid and o_fold_id SHALL be zero.
REQ-013 The datapath SHALL be two register stages (S1: per-axis decode, S2: combine/output); latency i_valid&i_ready to o_valid = 2 cycles when unstalled.
REQ-014 Throughput SHALL be one transfer per cycle with o_ready held high.
REQ-015 A stage SHALL load when empty or when its contents move forward the same cycle; i_ready = !S1_valid or S1 advancing (no combinational path from o_ready to i_ready beyond this chain).
REQ-016 o_valid/o_cid/o_fold_id/o_hit/o_data SHALL stay stable while o_valid=1 and o_ready=0.
REQ-017 With DROP_MISS=1, a miss SHALL leave S1 without entering S2 and never assert o_valid.
REQ-018 o_hit_cnt/o_miss_cnt SHALL increment once per item leaving S1 (hit or miss) and saturate at 2^32-1.
REQ-019 i_cnt_clr SHALL zero both counters next cycle; if coincident with an increment, the result SHALL be 0.
REQ-020 i_data SHALL be forwarded unmodified with its gcid result; order SHALL be preserved.

Reset
REQ-021 On rst_n low, both stage valids, o_valid, o_hit, o_cid, o_fold_id, o_data and both counters SHALL clear to 0 asynchronously; i_ready SHALL be 1 after release.
REQ-022 Reset mid-transfer SHALL discard all in-flight items without emitting them.

Structure
REQ-023 GLOBAL_CELL_ID_WIDTH, CELL_ID_WIDTH, CELL_FOLD_ID_WIDTH, NUM_CELL_FOLDS, X_DIM/Y_DIM/Z_DIM SHALL come from MD_pkg; no new package constants.
REQ-024 Per-axis decode SHALL be sub-module gcid_to_cid_1d (params GCELL_ID, DIM; out cid, fold_id, match), instantiated three times.

Verification (NUM_CELL_FOLDS=2, GLOBAL_CELL_ID_WIDTH=3, X/Y/Z_DIM=2, GCELL_X=GCELL_Y=GCELL_Z='{0,4})
REQ-025 gcid {z=5,y=1,x=4} -> after 2 cycles o_hit=1, cid {1,1,0}, fold_id {1,0,1}, hit_cnt=1.
REQ-026 gcid x=3, DROP_MISS=1 -> no o_valid, miss_cnt=1; DROP_MISS=0 -> o_valid with o_hit=0, cid=0.
REQ-027 Wrap: GCELL_X='{7,4}, x=0 -> hit, fold 0, cid_x 1.
REQ-028 10 back-to-back hits, o_ready low cycles 3-6 -> all 10 emitted in order, outputs stable while stalled, i_ready low once both stages full.
REQ-029 i_cnt_clr coincident with a hit -> hit_cnt 0; counter preset near 2^32-1 saturates.
REQ-030 rst_n low with 2 items in flight -> o_valid 0 immediately, nothing emitted after release.
